// File: rtl/fmul_share_arbiter.sv
// fmul_share_arbiter: round-robin sharing of one start/done FP32 multiplier among N requesters.
// Optional WAIT-state timeout abort is enabled by defining FMUL_ARB_TIMEOUT_EN.
module fmul_share_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*32-1:0] req_a,
    input  logic [N*32-1:0] req_b,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [31:0]     rsp_data,
    output logic            rsp_err,
    output logic            mul_start,
    output logic [31:0]     mul_a,
    output logic [31:0]     mul_b,
    input  logic [31:0]     mul_result,
    input  logic            mul_done,
    output logic            busy,
    output logic [IDW-1:0]  grant_id
);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("fmul_share_arbiter: N must be in 2..8");
    end
    if (IDW < $clog2(N)) begin : g_bad_idw
        $error("fmul_share_arbiter: IDW too narrow for N");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fmul_share_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [31:0]    mul_a_q, mul_a_d;
    logic [31:0]    mul_b_q, mul_b_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic [IDW:0]   pick;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;

`ifdef FMUL_ARB_TIMEOUT_EN
    localparam int          CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    // First requesting index at or above ptr, wrapping mod N; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] vld, input logic [IDW-1:0] ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            for (int i = 0; i < N; i++) begin
                if (idx == i && vld[i]) res = {1'b1, IDW'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) oh[i] = (idx == IDW'(i));
        return oh;
    endfunction

    function automatic logic [31:0] word_sel(input logic [N*32-1:0] bus, input logic [IDW-1:0] idx);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDW'(i)) w = bus[32*i +: 32];
        end
        return w;
    endfunction

    assign pick       = rr_pick(req_valid, rr_ptr_q);
    assign pick_found = pick[IDW];
    assign pick_idx   = pick[IDW-1:0];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
`ifdef FMUL_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        rsp_err_d  = rsp_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Ready is withheld during reset so no request is accepted and then lost.
                if (pick_found && rst_n) begin
                    req_ready = onehot(pick_idx);
                    grant_d   = pick_idx;
                    rr_ptr_d  = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
                    mul_a_d   = word_sel(req_a, pick_idx);
                    mul_b_d   = word_sel(req_b, pick_idx);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FMUL_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (mul_done) begin
                    rsp_data_d = mul_result;
                    state_d    = S_RESP;
`ifdef FMUL_ARB_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d = QNAN;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef FMUL_ARB_TIMEOUT_EN
                rsp_err_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_data_q <= '0;
`ifdef FMUL_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_data_q <= rsp_data_d;
`ifdef FMUL_ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    assign mul_start = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP) ? onehot(grant_q) : '0;
    assign rsp_data  = rsp_data_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign grant_id  = grant_q;
`ifdef FMUL_ARB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Self-checking bench for fmul_share_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model. Define FMUL_ARB_TIMEOUT_EN for timeout cases.
module tb_fmul_share_arbiter;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a, req_b;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [31:0]     rsp_data, mul_a, mul_b, mul_result;
    logic            rsp_err, mul_start, mul_done, busy;
    logic [IDW-1:0]  grant_id;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_ptr;
    bit          m_pend [N];
    logic [31:0] m_a [N];
    logic [31:0] m_b [N];
    logic [31:0] last_data;

    fmul_share_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Multiplier stand-in: exact products for the directed operand pairs, a fixed mix otherwise.
    function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return 32'h4010_0000;
        return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]};
    endfunction

    function automatic int exp_grant();
        int i;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (m_pend[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h7FC0_0000;
            1:       return 32'h0000_0000;
            2:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = 1'b1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        m_pend[i] = 1'b1;
        m_a[i]    = a;
        m_b[i]    = b;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
        m_pend[i]    = 1'b0;
    endtask

    // One full transaction from IDLE back to IDLE. lat: WAIT cycle carrying mul_done
    // (0 = never, timeout build only). spur: pulse mul_done during ISSUE.
    task automatic serve(input int lat, input bit refill, input bit spur);
        int             g, nw;
        bit             to;
        logic [31:0]    ea, eb, er;
        logic [N-1:0]   oh;
        to = 1'b0;
`ifdef FMUL_ARB_TIMEOUT_EN
        to = (lat == 0);
`endif
        nw = to ? TIMEOUT : lat;
        g  = exp_grant();
        oh = '0;
        oh[g] = 1'b1;
        ea = m_a[g];
        eb = m_b[g];
        er = to ? 32'h7FC0_0000 : mul_ref(ea, eb);
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'(oh));
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        chk("issue_start", 32'(mul_start), 32'd1);
        chk("issue_mul_a", mul_a, ea);
        chk("issue_mul_b", mul_b, eb);
        chk("issue_grant_id", 32'(grant_id), 32'(g));
        chk("issue_req_ready", 32'(req_ready), 32'd0);
        chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        m_ptr = (g + 1) % N;
        if (refill) set_req(g, rand_operand(), rand_operand());
        else        clr_req(g);
        if (spur) begin
            mul_done   = 1'b1;
            mul_result = $urandom;
        end
        tick();
        mul_done = 1'b0;
        for (int k = 1; k <= nw; k++) begin
            chk("wait_quiet", {29'd0, mul_start, rsp_valid != '0, busy}, 32'd1);
            if (k == lat) begin
                mul_done   = 1'b1;
                mul_result = mul_ref(mul_a, mul_b);
            end
            tick();
            mul_done = 1'b0;
        end
        chk("resp_rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("resp_rsp_data", rsp_data, er);
        chk("resp_rsp_err", 32'(rsp_err), 32'(to));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        last_data = er;
        tick();
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_rsp_err", 32'(rsp_err), 32'd0);
        chk("post_rsp_data_held", rsp_data, er);
        chk("post_mul_a_held", mul_a, ea);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    initial begin
        int lat;
        bit any;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        mul_done   = 1'b0;
        mul_result = '0;
        m_ptr      = 0;
        last_data  = '0;
        for (int i = 0; i < N; i++) set_req(i, rand_operand(), rand_operand());

        // Reset with every requester valid: nothing accepted, all outputs cleared.
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        chk("reset_req_ready2", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_mul_start", 32'(mul_start), 32'd0);
        chk("reset_mul_a", mul_a, 32'd0);
        chk("reset_mul_b", mul_b, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        rst_n = 1'b1;

        // Round robin with all four held valid: grants 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            serve(3, 1'b1, 1'b0);
            chk("rr_order", 32'(grant_id), 32'(t % N));
        end

        // Single request 2.0 * 3.0 with a 4-cycle multiplier.
        for (int i = 0; i < N; i++) clr_req(i);
        do_reset();
        set_req(0, 32'h4000_0000, 32'h4040_0000);
        serve(4, 1'b0, 1'b0);
        chk("single_product", rsp_data, 32'h40C0_0000);

        // Pointer wrap: req3 alone, then req1; then 3 followed by {0,1} shows wrap to 0.
        set_req(3, rand_operand(), rand_operand());
        serve(2, 1'b0, 1'b0);
        chk("wrap_grant3", 32'(grant_id), 32'd3);
        set_req(1, rand_operand(), rand_operand());
        serve(1, 1'b0, 1'b0);
        chk("wrap_grant1", 32'(grant_id), 32'd1);
        set_req(3, rand_operand(), rand_operand());
        serve(2, 1'b0, 1'b0);
        set_req(0, rand_operand(), rand_operand());
        set_req(1, rand_operand(), rand_operand());
        serve(1, 1'b0, 1'b0);
        chk("wrap_grant0", 32'(grant_id), 32'd0);
        serve(1, 1'b0, 1'b0);

        // Spurious done in IDLE, then in ISSUE during a 1.5 * 1.5 request.
        mul_done   = 1'b1;
        mul_result = 32'h1234_5678;
        tick();
        mul_done = 1'b0;
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("spur_idle_rsp_data", rsp_data, last_data);
        set_req(2, 32'h3FC0_0000, 32'h3FC0_0000);
        serve(3, 1'b0, 1'b1);
        chk("spur_product", rsp_data, 32'h4010_0000);

        // Reset during WAIT aborts; a stale done afterwards is ignored; pointer restarts at 0.
        set_req(2, rand_operand(), rand_operand());
        #1;
        chk("abort_ready", 32'(req_ready), 32'b0100);
        tick();
        clr_req(2);
        tick();
        tick();
        chk("abort_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        chk("abort_mul_a", mul_a, 32'd0);
        chk("abort_mul_b", mul_b, 32'd0);
        chk("abort_mul_start", 32'(mul_start), 32'd0);
        chk("abort_grant_id", 32'(grant_id), 32'd0);
        chk("abort_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        m_ptr = 0;
        mul_done   = 1'b1;
        mul_result = 32'hDEAD_BEEF;
        tick();
        mul_done = 1'b0;
        chk("stale_done_busy", 32'(busy), 32'd0);
        chk("stale_done_rsp_valid", 32'(rsp_valid), 32'd0);
        set_req(3, rand_operand(), rand_operand());
        set_req(0, rand_operand(), rand_operand());
        serve(2, 1'b0, 1'b0);
        chk("after_abort_grant", 32'(grant_id), 32'd0);
        serve(2, 1'b0, 1'b0);

`ifdef FMUL_ARB_TIMEOUT_EN
        // Multiplier silent: timeout after TIMEOUT WAIT cycles; done on the last cycle wins.
        set_req(1, rand_operand(), rand_operand());
        serve(0, 1'b0, 1'b0);
        chk("timeout_err_data", rsp_data, 32'h7FC0_0000);
        set_req(2, rand_operand(), rand_operand());
        serve(TIMEOUT, 1'b0, 1'b0);
`endif

        // Randomized traffic: arbitrary pending sets, drops, latencies and spurious dones.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && $urandom_range(0, 3) == 0) clr_req(i);
                else if (!m_pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, rand_operand(), rand_operand());
            end
            any = 1'b0;
            for (int i = 0; i < N; i++) any = any | m_pend[i];
            if (!any) set_req($urandom_range(0, N - 1), rand_operand(), rand_operand());
            lat = $urandom_range(1, 6);
            serve(lat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
